// File: rtl/scratch_arbiter_pkg.sv
// Shared types and constants for the scratch RAM arbiter.
package scratch_arbiter_pkg;

  localparam int unsigned SCR_ADDR_W = 8;
  localparam int unsigned SCR_DATA_W = 10;
  localparam int unsigned STAT_W     = 16;
  localparam int unsigned WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_WAIT,
    ARB_FORCE
  } arb_state_t;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/scratch_arbiter_if.sv
// CPU, DMA and RAM-side signals of the scratch arbiter; slave is the arbiter's view.
interface scratch_arbiter_if
  import scratch_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = SCR_ADDR_W,
  parameter int unsigned DATA_W = SCR_DATA_W
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dma_valid;
  logic              dma_ready;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dma_valid, dma_we, dma_addr, dma_wdata,
    output dma_ready, dma_rvalid, dma_rdata,
    output ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dma_valid, dma_we, dma_addr, dma_wdata,
    input  dma_ready, dma_rvalid, dma_rdata,
    input  ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/scratch_arbiter_stats.sv
// Saturating DMA-grant and CPU-stall counters; clear wins over increment.
module scratch_arbiter_stats
  import scratch_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              grant_i,
  input  logic              stall_i,
  output logic [STAT_W-1:0] dma_grants_o,
  output logic [STAT_W-1:0] cpu_stalls_o
);

  logic [STAT_W-1:0] grants_d, grants_q;
  logic [STAT_W-1:0] stalls_d, stalls_q;

  always_comb begin
    grants_d = grants_q;
    stalls_d = stalls_q;
    if (clr_i) begin
      grants_d = '0;
      stalls_d = '0;
    end else begin
      if (grant_i) grants_d = sat_inc(grants_q);
      if (stall_i) stalls_d = sat_inc(stalls_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grants_q <= '0;
      stalls_q <= '0;
    end else begin
      grants_q <= grants_d;
      stalls_q <= stalls_d;
    end
  end

  assign dma_grants_o = grants_q;
  assign cpu_stalls_o = stalls_q;

endmodule

// File: rtl/scratch_arbiter.sv
// Scratch RAM arbiter: CPU priority with a starvation-bounded DMA port.
// Optional counters enabled by defining SCRATCH_ARBITER_STATS_EN.
module scratch_arbiter
  import scratch_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned DATA_W   = SCR_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  scratch_arbiter_if.slave  bus,
  input  logic              stat_clr,
  output logic [STAT_W-1:0] stat_dma_grants,
  output logic [STAT_W-1:0] stat_cpu_stalls
);

  localparam logic [WAIT_CNT_W-1:0] ForceCnt = WAIT_CNT_W'(MAX_WAIT - 1);

  arb_state_t            state_d, state_q;
  logic [WAIT_CNT_W-1:0] wait_cnt_d, wait_cnt_q;
  logic                  dma_rvalid_d, dma_rvalid_q;
  logic [DATA_W-1:0]     dma_rdata_d, dma_rdata_q;

  logic starve;
  logic grant_dma;

  assign starve    = (state_q == ARB_FORCE);
  assign grant_dma = bus.dma_valid & (~bus.cpu_req | starve);

  assign bus.dma_ready  = grant_dma;
  assign bus.cpu_stall  = bus.cpu_req & grant_dma;
  assign bus.cpu_rdata  = bus.ram_rdata;
  assign bus.dma_rvalid = dma_rvalid_q;
  assign bus.dma_rdata  = dma_rdata_q;

  always_comb begin
    if (grant_dma) begin
      bus.ram_addr  = bus.dma_addr;
      bus.ram_wdata = bus.dma_wdata;
      bus.ram_we    = bus.dma_we;
    end else begin
      bus.ram_addr  = bus.cpu_addr;
      bus.ram_wdata = bus.cpu_wdata;
      bus.ram_we    = bus.cpu_req & bus.cpu_we;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (bus.dma_valid && bus.cpu_req) begin
          state_d    = ARB_WAIT;
          wait_cnt_d = WAIT_CNT_W'(1);
        end
      end
      ARB_WAIT: begin
        if (!bus.dma_valid || grant_dma) begin
          state_d    = ARB_IDLE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q >= ForceCnt) begin
          // >= so that MAX_WAIT=1 still escapes after one blocked WAIT cycle
          state_d = ARB_FORCE;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
        end
      end
      ARB_FORCE: begin
        state_d    = ARB_IDLE;
        wait_cnt_d = '0;
      end
      default: begin
        state_d    = ARB_IDLE;
        wait_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    dma_rvalid_d = grant_dma & ~bus.dma_we;
    dma_rdata_d  = dma_rvalid_d ? bus.ram_rdata : dma_rdata_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      wait_cnt_q   <= '0;
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      dma_rvalid_q <= dma_rvalid_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

`ifdef SCRATCH_ARBITER_STATS_EN
  scratch_arbiter_stats u_stats (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (stat_clr),
    .grant_i      (grant_dma),
    .stall_i      (bus.cpu_stall),
    .dma_grants_o (stat_dma_grants),
    .cpu_stalls_o (stat_cpu_stalls)
  );
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_dma_grants = '0;
  assign stat_cpu_stalls = '0;
`endif

endmodule

// File: tb/tb_scratch_arbiter.sv
// Scoreboard bench for scratch_arbiter: directed scenarios plus random traffic.
`timescale 1ns/1ps
module tb_scratch_arbiter;
  import scratch_arbiter_pkg::*;

  localparam int unsigned MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stat_clr = 1'b0;
  logic [STAT_W-1:0] stat_dma_grants, stat_cpu_stalls;

  scratch_arbiter_if bus ();

  scratch_arbiter #(.MAX_WAIT(MAX_WAIT), .DATA_W(SCR_DATA_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .stat_clr        (stat_clr),
    .stat_dma_grants (stat_dma_grants),
    .stat_cpu_stalls (stat_cpu_stalls)
  );

  always #5 clk = ~clk;

  // Scratch RAM: combinational read, write on the clock edge.
  logic [SCR_DATA_W-1:0] mem [256] = '{default: '0};
  assign bus.ram_rdata = mem[bus.ram_addr];
  always @(posedge clk) if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;

  typedef struct {
    logic                  ready;
    logic                  stall;
    logic                  we;
    logic [SCR_ADDR_W-1:0] addr;
    logic [SCR_DATA_W-1:0] wdata;
    logic                  rvalid;
    logic [SCR_DATA_W-1:0] rdata;
    logic                  chk_cpu;
    logic [SCR_DATA_W-1:0] cpu_rdata;
    logic [STAT_W-1:0]     sg;
    logic [STAT_W-1:0]     ss;
  } exp_t;

  exp_t                  comb_q[$];
  logic [SCR_DATA_W-1:0] rd_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [SCR_DATA_W-1:0] ref_mem [256] = '{default: '0};
  int unsigned           m_run = 0;
  bit                    m_prev_rd = 1'b0;
  logic [SCR_DATA_W-1:0] m_prev_data = '0;
  logic [SCR_DATA_W-1:0] m_last_rdata = '0;
  int unsigned           m_sg = 0;
  int unsigned           m_ss = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit creq, input bit cwe, input logic [7:0] caddr,
                       input logic [9:0] cwd, input bit dv, input bit dwe,
                       input logic [7:0] daddr, input logic [9:0] dwd, input bit clr);
    exp_t e;
    bit   grant;
    @(posedge clk);
    #1;
    bus.cpu_req   = creq;
    bus.cpu_we    = cwe;
    bus.cpu_addr  = caddr;
    bus.cpu_wdata = cwd;
    bus.dma_valid = dv;
    bus.dma_we    = dwe;
    bus.dma_addr  = daddr;
    bus.dma_wdata = dwd;
    stat_clr      = clr;

    e.rvalid = m_prev_rd;
    if (m_prev_rd) m_last_rdata = m_prev_data;
    e.rdata = m_last_rdata;

    // DMA wins if CPU idle, or once it has been blocked MAX_WAIT cycles in a row
    grant   = dv && (!creq || (m_run >= MAX_WAIT));
    e.ready = grant;
    e.stall = creq && grant;
    if (grant) begin
      e.we = dwe; e.addr = daddr; e.wdata = dwd;
    end else begin
      e.we = creq && cwe; e.addr = caddr; e.wdata = cwd;
    end
    e.chk_cpu   = creq && !grant && !cwe;
    e.cpu_rdata = ref_mem[caddr];
`ifdef SCRATCH_ARBITER_STATS_EN
    e.sg = STAT_W'(m_sg);
    e.ss = STAT_W'(m_ss);
`else
    e.sg = '0;
    e.ss = '0;
`endif
    comb_q.push_back(e);

    m_prev_rd   = grant && !dwe;
    m_prev_data = ref_mem[daddr];
    if (m_prev_rd) rd_q.push_back(ref_mem[daddr]);
    if (grant && dwe) ref_mem[daddr] = dwd;
    else if (!grant && creq && cwe) ref_mem[caddr] = cwd;

    if (dv && !grant) m_run++;
    else m_run = 0;

    if (clr) begin
      m_sg = 0; m_ss = 0;
    end else begin
      if (grant && m_sg < 32'hFFFF) m_sg++;
      if (creq && grant && m_ss < 32'hFFFF) m_ss++;
    end
  endtask

  task automatic idle();
    drive(0, 0, 8'h00, 10'h000, 0, 0, 8'h00, 10'h000, 0);
  endtask

  task automatic mid_reset(input bit exp_rv);
    @(posedge clk);
    #1;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.dma_valid = 0; bus.dma_we = 0; stat_clr = 0;
    check("rvalid_before_rst", bus.dma_rvalid, exp_rv);
    #1 rst = 1'b1;
    #1;
    check("rst_rvalid", bus.dma_rvalid, 0);
    check("rst_rdata", bus.dma_rdata, 0);
    check("rst_ram_we", bus.ram_we, 0);
    check("rst_dma_ready", bus.dma_ready, 0);
    check("rst_cpu_stall", bus.cpu_stall, 0);
    check("rst_stat_grants", stat_dma_grants, 0);
    comb_q.delete();
    rd_q.delete();
    m_run = 0; m_prev_rd = 0; m_last_rdata = '0; m_sg = 0; m_ss = 0;
    @(posedge clk);
    #3 rst = 1'b0;
  endtask

  // Monitor: one expectation per driven cycle, read data popped on dma_rvalid
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (comb_q.size() > 0) begin
        e = comb_q.pop_front();
        check("dma_ready", bus.dma_ready, e.ready);
        check("cpu_stall", bus.cpu_stall, e.stall);
        check("ram_we", bus.ram_we, e.we);
        check("ram_addr", bus.ram_addr, e.addr);
        check("ram_wdata", bus.ram_wdata, e.wdata);
        check("dma_rvalid", bus.dma_rvalid, e.rvalid);
        check("dma_rdata_hold", bus.dma_rdata, e.rdata);
        check("stat_dma_grants", stat_dma_grants, e.sg);
        check("stat_cpu_stalls", stat_cpu_stalls, e.ss);
        if (e.chk_cpu) check("cpu_rdata", bus.cpu_rdata, e.cpu_rdata);
        if (bus.dma_rvalid) begin
          if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
          else check("dma_rdata", bus.dma_rdata, rd_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_valid = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;
    #3;
    check("init_rvalid", bus.dma_rvalid, 0);
    check("init_rdata", bus.dma_rdata, 0);
    check("init_ram_we", bus.ram_we, 0);
    check("init_dma_ready", bus.dma_ready, 0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;

    // DMA-only read of a preloaded word
    drive(1, 1, 8'h20, 10'h155, 0, 0, 8'h00, 10'h000, 0);
    drive(0, 0, 8'h00, 10'h000, 1, 0, 8'h20, 10'h000, 0);
    idle();

    // CPU priority: forced grant on the fifth contended cycle, then CPU runs
    for (int i = 0; i < 9; i++) drive(1, 0, 8'h05, 10'h000, 1, 0, 8'h20, 10'h000, 0);
    idle();

    // Forced write with a stalled CPU write retried the next cycle
    for (int i = 0; i < 4; i++) drive(1, 0, 8'h11, 10'h000, 1, 1, 8'hFF, 10'h3A5, 0);
    drive(1, 1, 8'h10, 10'h2AA, 1, 1, 8'hFF, 10'h3A5, 0);
    drive(1, 1, 8'h10, 10'h2AA, 0, 0, 8'h00, 10'h000, 0);
    idle();
    check("ram_ff_written", mem[8'hFF], 10'h3A5);
    check("ram_10_retried", mem[8'h10], 10'h2AA);

    // Withdrawal after two blocked cycles, then a full wait again
    for (int i = 0; i < 2; i++) drive(1, 0, 8'h01, 10'h000, 1, 0, 8'h10, 10'h000, 0);
    drive(1, 0, 8'h01, 10'h000, 0, 0, 8'h10, 10'h000, 0);
    for (int i = 0; i < 6; i++) drive(1, 0, 8'h01, 10'h000, 1, 0, 8'h10, 10'h000, 0);
    idle();

    // Async reset with a read response due, and again mid-wait
    drive(0, 0, 8'h00, 10'h000, 1, 0, 8'hFF, 10'h000, 0);
    mid_reset(1);
    for (int i = 0; i < 3; i++) drive(1, 0, 8'h02, 10'h000, 1, 0, 8'h10, 10'h000, 0);
    mid_reset(0);
    for (int i = 0; i < 5; i++) drive(1, 0, 8'h02, 10'h000, 1, 0, 8'h10, 10'h000, 0);
    idle();

`ifdef SCRATCH_ARBITER_STATS_EN
    mid_reset(0);
    for (int i = 0; i < 3; i++) drive(0, 0, 8'h00, 10'h000, 1, 1, 8'(8'h40 + i), 10'h011, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, 8'h03, 10'h000, 1, 0, 8'h40, 10'h000, 0);
    idle();
    @(negedge clk);
    check("stats_grants_4", stat_dma_grants, 4);
    check("stats_stalls_1", stat_cpu_stalls, 1);
    drive(0, 0, 8'h00, 10'h000, 1, 0, 8'h40, 10'h000, 1);
    idle();
    @(negedge clk);
    check("stats_clr_grants", stat_dma_grants, 0);
    check("stats_clr_stalls", stat_cpu_stalls, 0);
`endif

    // Random traffic over a small address window for read-after-write hits
    for (int i = 0; i < 400; i++) begin
      bit   creq, cwe, dv, dwe, clr;
      logic [7:0] ca, da;
      creq = ($urandom_range(0, 3) != 0);
      cwe  = $urandom_range(0, 1) != 0;
      dv   = ($urandom_range(0, 2) != 0);
      dwe  = $urandom_range(0, 1) != 0;
      clr  = ($urandom_range(0, 31) == 0);
      ca   = 8'($urandom_range(0, 15));
      da   = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
      drive(creq, cwe, ca, 10'($urandom), dv, dwe, da, 10'($urandom), clr);
      if (i == 200) mid_reset(m_prev_rd);
    end
    idle();
    idle();
    @(negedge clk);
    #1;
    check("rd_q_drained", rd_q.size(), 0);
    check("comb_q_drained", comb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scratch_arbiter.md
Name: scratch_arbiter

Overview:
- Shares the single-port scratch RAM between the CPU execute stage and one external DMA/debug requester.
- The CPU has priority. A starvation counter guarantees the DMA is served within MAX_WAIT cycles; when it is, the arbiter stalls the CPU for one cycle.
- Sits between the execute-stage scratch address/data muxes and the SCRATCH_RAM. cpu_stall feeds pipeline_control as an additional freeze source.

Parameters:
- ADDR_W, 8, scratch address width.
- DATA_W, 10, scratch data width (holds a full PC for CALL/RET).
- MAX_WAIT, 4, consecutive blocked DMA cycles before a forced grant; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  execute stage accesses scratch RAM this cycle (read or write)
- cpu_we  in  1  CPU write enable (qualified by cpu_req)
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  combinational passthrough of ram_rdata
- cpu_stall  out  1  CPU access not performed this cycle; pipeline must hold execute stage
- dma_valid  in  1  DMA request pending
- dma_ready  out  1  DMA request accepted this cycle
- dma_we  in  1  DMA write enable
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_rvalid  out  1  DMA read data valid
- dma_rdata  out  DATA_W  DMA read data
- ram_we  out  1  to SCRATCH_RAM WE
- ram_addr  out  ADDR_W  to SCRATCH_RAM ADDR
- ram_wdata  out  DATA_W  to SCRATCH_RAM DATA_IN
- ram_rdata  in  DATA_W  from SCRATCH_RAM DATA_OUT (combinational read)

Behaviour:
- Reset (async, rst=1): state=ARB_IDLE, wait_cnt=0, dma_rvalid=0, dma_rdata=0. All combinational outputs follow the idle equations below.
- Combinational grant:
  - starve = (state==ARB_FORCE)
  - grant_dma = dma_valid & (!cpu_req | starve)
  - dma_ready = grant_dma
  - cpu_stall = cpu_req & grant_dma
- RAM mux:
  - grant_dma=1: ram_addr=dma_addr, ram_wdata=dma_wdata, ram_we=dma_we.
  - Otherwise: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_req&cpu_we.
  - Idle (no request): ram_we=0, address/data follow the CPU inputs.
- FSM (registered on posedge clk):
  - ARB_IDLE: dma_valid & cpu_req -> ARB_WAIT with wait_cnt=1. Otherwise stay.
  - ARB_WAIT:
    - dma_valid=0 or grant_dma -> ARB_IDLE, wait_cnt=0.
    - Blocked and wait_cnt==MAX_WAIT-1 -> ARB_FORCE.
    - Otherwise wait_cnt+1.
  - ARB_FORCE: DMA always granted if dma_valid -> ARB_IDLE, wait_cnt=0. dma_valid dropped -> ARB_IDLE, no grant.
- A DMA request withdrawn while waiting is legal; the counter clears.
- Fairness: after a forced grant the CPU keeps priority for at least MAX_WAIT cycles. Forced stalls never occur on consecutive cycles.
- MAX_WAIT=1: ARB_WAIT transitions straight to ARB_FORCE after one blocked cycle.
- DMA read latency 1: on a grant with dma_we=0, the next edge sets dma_rvalid=1 and dma_rdata=ram_rdata. Otherwise dma_rvalid=0 next cycle. dma_rdata holds its last value.
- DMA write: takes effect at the RAM on the grant edge; no response.
- A CPU access stalled by a forced grant is retried the next cycle; the arbiter stores no CPU state.
- rst asserted mid-wait: forced grant pending is discarded and dma_rvalid clears immediately.

Optional Feature:
- Macro: SCRATCH_ARBITER_STATS_EN.
- Defined:
  - Adds input stat_clr (1b) and outputs stat_dma_grants (16b) and stat_cpu_stalls (16b).
  - Counters increment on grant_dma and on cpu_stall respectively, saturating at 16'hFFFF.
  - Synchronous stat_clr zeroes both counters and has priority over increments. Async rst zeroes both.
- Undefined: the ports remain; stat_dma_grants and stat_cpu_stalls are tied to 0, stat_clr is ignored, and no counter flops exist.

Decomposition:
- Package scratch_arbiter_pkg: arb_state_t enum {ARB_IDLE, ARB_WAIT, ARB_FORCE}, SCR_ADDR_W=8, SCR_DATA_W=10, STAT_W=16.
- One sub-module, scratch_arbiter_stats: the two saturating counters, instantiated only under the macro.
- Grant logic and FSM stay in the top module.

Test Plan:
- Reset check: rst pulse mid-cycle -> all registered outputs 0 asynchronously; state ARB_IDLE; ram_we=0 with no requests.
- DMA-only read: cpu_req=0; dma_valid=1, dma_we=0, dma_addr=8'h20; RAM[0x20]=10'h155 -> dma_ready=1 same cycle; next cycle dma_rvalid=1, dma_rdata=10'h155; cpu_stall never 1.
- CPU priority: cpu_req=1 continuously, dma_valid=1, MAX_WAIT=4 -> dma_ready=0 for cycles 0..3; cycle 4 dma_ready=1 and cpu_stall=1; cycles 5..8 CPU unstalled.
- Forced write: same as above with dma_we=1, dma_addr=8'hFF, dma_wdata=10'h3A5 -> RAM[0xFF]=10'h3A5 after the forced cycle; a CPU write to 8'h10 stalled in that cycle lands one cycle later.
- Withdrawal: dma_valid high 2 cycles under cpu_req, then low -> state returns to ARB_IDLE, wait_cnt=0, no grant; re-request waits a full MAX_WAIT again.
- Stats (macro defined): 3 free DMA grants + 1 forced -> stat_dma_grants=4, stat_cpu_stalls=1; stat_clr=1 -> both 0 next cycle.
